divider_32bit: RTL and testbench

Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the execute stage alongside the ALU. It drives operands into an internal instance of the team's 32-bit ripple-borrow subtractor (`subtractor_32bit`) once per cycle and consumes its difference and borrow to decide each quotient bit. The pipeline stalls on `busy_o` and picks up the result on `valid_o`.

---
 rtl/divider_32bit.sv | 163 ++++++++++++++++
 tb/tb_divider_32bit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/divider_32bit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle through a 32-bit ripple-borrow subtractor.

module subtractor_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] diff,
  output logic        borrow
);

  logic [32:0] bw;

  assign bw[0] = 1'b0;

  for (genvar i = 0; i < 32; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign borrow = bw[32];

endmodule

module divider_32bit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] rem_r;
  logic [31:0] quot_r;
  logic [31:0] div_r;
  logic        quot_neg;
  logic        rem_neg;
  logic        is_rem;

  logic [31:0] shifted;
  logic [31:0] sub_diff;
  logic        sub_borrow;
  logic        accept;
  logic [31:0] rem_next;
  logic [31:0] quot_next;
  logic [31:0] fix_res;

  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        div_zero;
  logic        overflow;
  logic [31:0] special_res;

  subtractor_32bit u_sub (
    .a      (shifted),
    .b      (div_r),
    .diff   (sub_diff),
    .borrow (sub_borrow)
  );

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    shifted   = {rem_r[30:0], quot_r[31]};
    // A set carry bit means the shifted remainder exceeds 2^32 > divisor.
    accept    = rem_r[31] | ~sub_borrow;
    rem_next  = accept ? sub_diff : shifted;
    quot_next = {quot_r[30:0], accept};
    fix_res   = quot_next;
    if (is_rem) begin
      fix_res = rem_neg ? (~rem_next + 32'd1) : rem_next;
    end else begin
      fix_res = quot_neg ? (~quot_next + 32'd1) : quot_next;
    end
  end

  always_comb begin
    op_signed   = ~op_i[0];
    a_neg       = op_signed & a_i[31];
    b_neg       = op_signed & b_i[31];
    a_mag       = a_neg ? (~a_i + 32'd1) : a_i;
    b_mag       = b_neg ? (~b_i + 32'd1) : b_i;
    div_zero    = (b_i == 32'd0);
    overflow    = op_signed & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
    special_res = 32'd0;
    if (div_zero) begin
      special_res = op_i[1] ? a_i : 32'hFFFF_FFFF;
    end else if (overflow) begin
      special_res = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      count    <= 5'd0;
      rem_r    <= 32'd0;
      quot_r   <= 32'd0;
      div_r    <= 32'd0;
      quot_neg <= 1'b0;
      rem_neg  <= 1'b0;
      is_rem   <= 1'b0;
      busy_o   <= 1'b0;
      valid_o  <= 1'b0;
      result_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            is_rem <= op_i[1];
            busy_o <= 1'b1;
            if (div_zero || overflow) begin
              state    <= DONE;
              valid_o  <= 1'b1;
              result_o <= special_res;
            end else begin
              state    <= CALC;
              count    <= 5'd0;
              rem_r    <= 32'd0;
              quot_r   <= a_mag;
              div_r    <= b_mag;
              quot_neg <= a_neg ^ b_neg;
              rem_neg  <= a_neg;
            end
          end
        end
        CALC: begin
          rem_r  <= rem_next;
          quot_r <= quot_next;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            state    <= DONE;
            valid_o  <= 1'b1;
            result_o <= fix_res;
          end
        end
        DONE: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_32bit.sv
// Directed self-checking bench for divider_32bit: results, latency,
// special cases, dropped starts and mid-operation reset.

module tb_divider_32bit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks   = 0;
  int failures = 0;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  divider_32bit dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the divider idle; returns #1 after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    a_i     = 32'hDEAD_BEEF;
    b_i     = 32'h0BAD_F00D;
  endtask

  // n counts rising edges since (and including) the accept edge.
  task automatic wait_valid(input int n_start, output int n);
    n = n_start;
    while (!valid_o && n < 64) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic finish_op(input string tag, input int n, input logic [31:0] exp_res, input int exp_lat);
    check({tag, "_valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_res"}, result_o, exp_res);
    check({tag, "_busy_done"}, {31'd0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
    check({tag, "_valid_fall"}, {31'd0, valid_o}, 32'd0);
    check({tag, "_busy_fall"}, {31'd0, busy_o}, 32'd0);
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int n;
    issue(op, a, b);
    wait_valid(1, n);
    finish_op(tag, n, exp_res, exp_lat);
  endtask

  task automatic count_valids(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) pulses++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst_i   = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 32'd0;
    b_i     = 32'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Basic unsigned and signed results, 33-cycle latency.
    do_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    do_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    do_op("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    do_op("div_m7_m2",  OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);

    // Large unsigned operands, remainder above 2^31.
    do_op("divu_max_1",    OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    do_op("divu_max_big",  OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
    do_op("remu_max_big",  OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33);
    do_op("remu_big_max",  OP_REMU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);

    // Division by zero, 1-cycle latency.
    do_op("div_by0",  OP_DIV,  32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("divu_by0", OP_DIVU, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    do_op("rem_by0",  OP_REM,  32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    do_op("remu_by0", OP_REMU, 32'h8765_4321, 32'd0, 32'h8765_4321, 1);

    // Signed overflow and its unsigned counterpart.
    do_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    do_op("divu_ovf", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // A start pulse during CALC is dropped.
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (9) begin @(posedge clk_i); #1; end
    check("glitch_busy", {31'd0, busy_o}, 32'd1);
    start_i = 1'b1;
    op_i    = OP_DIV;
    a_i     = 32'd5;
    b_i     = 32'd0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_valid(11, n);
    finish_op("glitch", n, 32'd14, 33);
    count_valids(40, pulses);
    check("glitch_no_extra", 32'(pulses), 32'd0);

    // Reset mid-CALC clears outputs at once and yields no valid.
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (19) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    count_valids(40, pulses);
    check("midrst_no_valid", 32'(pulses), 32'd0);
    check("midrst_result_held", result_o, 32'd0);

    do_op("post_rst", OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);
    do_op("post_rst_rem", OP_REMU, 32'd1000, 32'd3, 32'd1, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
